// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word type and MEM-stage access controller states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    HALTED
  } dmem_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Holds at all-ones instead of wrapping back to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data cache request, stall and sticky halt controller
module dmem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pipe_en,
  input  logic             valid_in,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  word_t            addr_in,
  input  word_t            storeData_in,
  input  logic             halt_in,
  input  logic             dhit,
  input  word_t            dmemload,
  output logic             dREN,
  output logic             dWEN,
  output word_t            daddr,
  output word_t            dmemstore,
  output word_t            dmemload_out,
  output logic             mem_stall,
  output logic             halt_out,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  dmem_state_t state, state_n;
  word_t       load_q;
  logic        mem_op;
  logic        halt_req;
  logic        req;
  logic        done;

  assign mem_op   = valid_in & (memRead_in | memWrite_in);
  assign halt_req = valid_in & halt_in;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      load_q <= '0;
    end else begin
      state <= state_n;
      if (done) begin
        load_q <= dmemload;
      end
    end
  end

  // Requests only ever originate in IDLE; HOLD and HALTED keep the cache quiet.
  always_comb begin
    state_n = state;
    req     = 1'b0;
    case (state)
      IDLE: begin
        if (halt_req) begin
          if (pipe_en) begin
            state_n = HALTED;
          end
        end else begin
          req = mem_op;
          if (mem_op && dhit && !pipe_en) begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (pipe_en) begin
          state_n = IDLE;
        end
      end
      HALTED: state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  assign done      = req & dhit;
  assign dWEN      = req & memWrite_in;
  assign dREN      = req & memRead_in & ~memWrite_in;
  assign mem_stall = req & ~dhit;
  assign daddr     = addr_in & 32'hFFFF_FFFC;
  assign dmemstore = storeData_in;
  assign halt_out  = (state == HALTED);

  assign dmemload_out = ((state == IDLE) && dhit) ? dmemload : load_q;

  sat_counter #(.W(CNT_W)) u_access_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (done),
    .cnt (access_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (mem_stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed vector bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pipe_en, valid_in, memRead_in, memWrite_in, halt_in, dhit;
  logic [31:0] addr_in, storeData_in, dmemload;
  logic        dREN, dWEN, mem_stall, halt_out;
  logic [31:0] daddr, dmemstore, dmemload_out;
  logic [15:0] access_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  dmem_access_ctrl #(.CNT_W(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pipe_en      (pipe_en),
    .valid_in     (valid_in),
    .memRead_in   (memRead_in),
    .memWrite_in  (memWrite_in),
    .addr_in      (addr_in),
    .storeData_in (storeData_in),
    .halt_in      (halt_in),
    .dhit         (dhit),
    .dmemload     (dmemload),
    .dREN         (dREN),
    .dWEN         (dWEN),
    .daddr        (daddr),
    .dmemstore    (dmemstore),
    .dmemload_out (dmemload_out),
    .mem_stall    (mem_stall),
    .halt_out     (halt_out),
    .access_cnt   (access_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid, rd, wr, halt, pen, hit;
    logic [31:0] addr, sdata, mload;
    logic        e_dren, e_dwen, e_stall;
    logic [31:0] e_daddr, e_mout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic h, input logic pe,
                       input logic hit, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] ml);
    valid_in = v; memRead_in = r; memWrite_in = w; halt_in = h; pipe_en = pe;
    dhit = hit; addr_in = a; storeData_in = sd; dmemload = ml;
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_in();
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1,1,0,0,1,1, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 1,0,0, 32'h0000_0104, 32'hDEAD_BEEF};
    vecs[1] = '{1,1,0,0,1,0, 32'h0000_0207, 32'h0,         32'h5555_5555, 1,0,1, 32'h0000_0204, 32'hDEAD_BEEF};
    vecs[2] = '{1,1,1,0,1,1, 32'h0000_0030, 32'hA5A5_A5A5, 32'h1111_1111, 0,1,0, 32'h0000_0030, 32'h1111_1111};
    vecs[3] = '{0,1,0,0,1,0, 32'h0000_0044, 32'h0,         32'h7777_7777, 0,0,0, 32'h0000_0044, 32'h1111_1111};
    vecs[4] = '{1,0,0,0,1,1, 32'h0000_0048, 32'h0,         32'h2222_2222, 0,0,0, 32'h0000_0048, 32'h2222_2222};
    vecs[5] = '{1,0,1,0,1,0, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h3333_3333, 0,1,1, 32'hFFFF_FFFC, 32'h1111_1111};

    do_reset();
    chk("rst_access_cnt", 32'(access_cnt), 32'h0);
    chk("rst_stall_cnt",  32'(stall_cnt),  32'h0);
    chk("rst_halt_out",   32'(halt_out),   32'h0);
    chk("rst_dren",       32'(dREN),       32'h0);
    chk("rst_dwen",       32'(dWEN),       32'h0);
    chk("rst_stall",      32'(mem_stall),  32'h0);
    chk("rst_mout",       dmemload_out,    32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].halt, vecs[i].pen, vecs[i].hit,
            vecs[i].addr, vecs[i].sdata, vecs[i].mload);
      chk($sformatf("v%0d_dren", i),  32'(dREN),      32'(vecs[i].e_dren));
      chk($sformatf("v%0d_dwen", i),  32'(dWEN),      32'(vecs[i].e_dwen));
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_daddr", i), daddr,          vecs[i].e_daddr);
      chk($sformatf("v%0d_dstore", i), dmemstore,     vecs[i].sdata);
      chk($sformatf("v%0d_mout", i),  dmemload_out,   vecs[i].e_mout);
      tick();
    end
    idle_in();
    chk("tbl_access_cnt", 32'(access_cnt), 32'd2);
    chk("tbl_stall_cnt",  32'(stall_cnt),  32'd2);

    // store 0x12345678 to 0x206, hit on the fourth cycle
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 1, 0, 1, (c == 3), 32'h0000_0206, 32'h1234_5678, 32'h0);
      chk($sformatf("st_c%0d_dwen", c),  32'(dWEN),      32'h1);
      chk($sformatf("st_c%0d_daddr", c), daddr,          32'h0000_0204);
      chk($sformatf("st_c%0d_data", c),  dmemstore,      32'h1234_5678);
      chk($sformatf("st_c%0d_stall", c), 32'(mem_stall), (c == 3) ? 32'h0 : 32'h1);
      tick();
    end
    idle_in();
    chk("st_stall_cnt",  32'(stall_cnt),  32'd3);
    chk("st_access_cnt", 32'(access_cnt), 32'd1);

    // load hit while frozen, then two more frozen cycles
    drive(1, 1, 0, 0, 0, 1, 32'h0000_0040, 32'h0, 32'hCAFE_F00D);
    chk("hold_c0_dren", 32'(dREN),    32'h1);
    chk("hold_c0_mout", dmemload_out, 32'hCAFE_F00D);
    tick();
    for (int c = 1; c < 3; c++) begin
      drive(1, 1, 0, 0, (c == 2), 0, 32'h0000_0040, 32'h0, 32'h0);
      chk($sformatf("hold_c%0d_dren", c),  32'(dREN),      32'h0);
      chk($sformatf("hold_c%0d_stall", c), 32'(mem_stall), 32'h0);
      chk($sformatf("hold_c%0d_mout", c),  dmemload_out,   32'hCAFE_F00D);
      tick();
    end
    idle_in();
    chk("hold_access_cnt", 32'(access_cnt), 32'd2);
    chk("hold_stall_cnt",  32'(stall_cnt),  32'd3);

    // reset in the second cycle of a missing store
    drive(1, 0, 1, 0, 1, 0, 32'h0000_0300, 32'h0000_00AA, 32'h0);
    chk("rstmid_c0_dwen", 32'(dWEN), 32'h1);
    tick();
    RST = 1'b1;
    #1;
    tick();
    RST = 1'b0;
    idle_in();
    chk("rstmid_dwen",       32'(dWEN),       32'h0);
    chk("rstmid_access_cnt", 32'(access_cnt), 32'h0);
    chk("rstmid_stall_cnt",  32'(stall_cnt),  32'h0);
    drive(1, 1, 0, 0, 1, 1, 32'h0000_0500, 32'h0, 32'h0000_BEEF);
    chk("rstmid_idle_dren",  32'(dREN),      32'h1);
    chk("rstmid_idle_stall", 32'(mem_stall), 32'h0);
    tick();
    idle_in();
    chk("rstmid_after_access", 32'(access_cnt), 32'd1);

    // halt, then memory ops must be ignored
    drive(1, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0);
    tick();
    idle_in();
    chk("halt_set", 32'(halt_out), 32'h1);
    for (int c = 0; c < 3; c++) begin
      drive(1, (c != 1), (c == 1), 0, 1, 0, 32'h0000_0600, 32'h0000_0011, 32'h0);
      chk($sformatf("halt_c%0d_dren", c),  32'(dREN),      32'h0);
      chk($sformatf("halt_c%0d_dwen", c),  32'(dWEN),      32'h0);
      chk($sformatf("halt_c%0d_stall", c), 32'(mem_stall), 32'h0);
      tick();
      chk($sformatf("halt_c%0d_sticky", c), 32'(halt_out), 32'h1);
    end
    idle_in();
    chk("halt_access_cnt", 32'(access_cnt), 32'd1);

    // stall counter saturation
    do_reset();
    drive(1, 1, 0, 0, 1, 0, 32'h0000_0700, 32'h0, 32'h0);
    for (int c = 0; c < 65534; c++) tick();
    chk("sat_before", 32'(stall_cnt), 32'h0000_FFFE);
    tick();
    chk("sat_reach", 32'(stall_cnt), 32'h0000_FFFF);
    for (int c = 0; c < 4; c++) tick();
    chk("sat_hold",   32'(stall_cnt),  32'h0000_FFFF);
    chk("sat_access", 32'(access_cnt), 32'h0);
    chk("sat_dren",   32'(dREN),       32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-access controller for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register outputs and the MEM/WB pipeline register inputs. It issues load/store requests to the data cache, stalls the pipeline until `dhit`, and supplies the load word that the MEM/WB register captures as `dmemload_in`. It guarantees exactly one cache access per memory instruction, even while the pipeline is frozen by an instruction miss, and it owns the sticky halt hand-off to writeback.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating performance counters.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `pipe_en`  in  1  pipeline registers advance this cycle (from hazard unit; already includes `ihit`).
- `valid_in`  in  1  EX/MEM holds a live instruction (not a bubble).
- `memRead_in`  in  1  instruction is a load.
- `memWrite_in`  in  1  instruction is a store.
- `addr_in`  in  32  ALU-computed effective address.
- `storeData_in`  in  32  rt value to store.
- `halt_in`  in  1  instruction is HALT.
- `dhit`  in  1  cache access complete this cycle.
- `dmemload`  in  32  cache read data, valid with `dhit`.
- `dREN`  out  1  cache read request.
- `dWEN`  out  1  cache write request.
- `daddr`  out  32  word-aligned request address.
- `dmemstore`  out  32  store data.
- `dmemload_out`  out  32  load word to MEM/WB.
- `mem_stall`  out  1  freeze IF..MEM this cycle.
- `halt_out`  out  1  sticky halt to MEM/WB.
- `access_cnt`  out  CNT_W  completed accesses, saturating.
- `stall_cnt`  out  CNT_W  cycles with `mem_stall`=1, saturating.

## Operation
- `mem_op` = `valid_in & (memRead_in | memWrite_in)`.
- When both read and write are set, the access is a write: `dWEN` is asserted and `dREN` stays 0.
- `daddr` = {`addr_in[31:2]`, 2'b00}.
- `dmemstore` = `storeData_in`, driven combinationally.

States:
- IDLE (reset state):
  - When `mem_op`, drive `dREN`/`dWEN` combinationally in the same cycle.
  - `mem_stall` = `mem_op & ~dhit`.
  - On `dhit`: capture `dmemload` into `load_q` and increment `access_cnt`.
  - After `dhit`: go to HOLD if `pipe_en`=0, otherwise stay in IDLE.
  - No separate BUSY state. A request stays in IDLE, asserted, until `dhit`.
- HOLD:
  - The access is done but the instruction has not left MEM.
  - `dREN`/`dWEN`=0, so a frozen store is never re-issued.
  - `mem_stall`=0.
  - `dmemload_out`=`load_q`.
  - Go to IDLE on `pipe_en`.
- HALTED:
  - Entered when `valid_in & halt_in & pipe_en` and no access is pending.
  - `halt_out`=1.
  - `dREN`/`dWEN`=0 permanently.
  - `mem_stall`=0.
  - Only `RST` exits.

Output values:
- `dmemload_out` = `dhit ? dmemload : load_q`.
- `stall_cnt` increments on every cycle where `mem_stall`=1.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Reset values: state=IDLE, `load_q`=0, `access_cnt`=0, `stall_cnt`=0, `halt_out`=0. All outputs are 0, except outputs driven combinationally from inputs while IDLE.
- Best-case latency: 0 extra cycles. If `dhit` arrives in the same cycle as the request, `mem_stall` stays 0.
- A miss costs N stall cycles for N cycles of `~dhit`. `mem_stall` drops in the `dhit` cycle.
- The request is held stable (address, data, enables) until `dhit`. No deassert-and-retry is allowed.
- `dhit` with `pipe_en`=0: one access only. The controller goes to HOLD, and `load_q` supplies the data until MEM/WB captures it.
- `RST` mid-request: request enables fall the cycle after `RST`. Counters clear. The partial access is abandoned.
- `halt_in` together with `mem_op` cannot occur (HALT is not a memory op); `halt_in` has priority.
- Counter saturation: at the all-ones value, further increments are ignored.

## Structure
- `cpu_types_pkg` gains `dmem_state_t` (IDLE, HOLD, HALTED) and reuses `word_t`.
- Sub-module `sat_counter` (parameter `W`; ports `CLK`, `RST`, `inc`, `cnt`), instantiated twice.

## Test plan
- Load to 0x104 with `dhit` in the same cycle, `dmemload`=0xDEADBEEF:
  - `daddr`=0x104, `dREN`=1.
  - `mem_stall` never 1.
  - `dmemload_out`=0xDEADBEEF.
  - `access_cnt`=1.
- Store 0x12345678 to 0x206 with `dhit` after 3 cycles:
  - `daddr`=0x204, `dWEN` held for 4 cycles.
  - `mem_stall`=1 for exactly 3 cycles.
  - `stall_cnt`=3.
- Load hit while `pipe_en`=0 for 2 more cycles:
  - `dREN` drops after the hit and is not reasserted.
  - `dmemload_out` holds the hit data.
  - `access_cnt`=1.
- Both `memRead_in` and `memWrite_in` set: `dWEN`=1, `dREN`=0.
- `RST` during the 2nd cycle of a missing store:
  - The next cycle shows `dWEN`=0, counters=0, state=IDLE.
  - A later HALT with `pipe_en` gives `halt_out`=1 sticky, and no requests are issued for the following memory ops.
- Force 65535 stall cycles: `stall_cnt` stops at 0xFFFF.
